// File: rtl/bit_reversal_buffer.sv
// rtl/bit_reversal_buffer.sv - ping-pong frame buffer emitting natural or bit-reversed word order
// Optional BITREV_FRAME_FLAGS_EN adds out_first/out_last frame markers.
module bit_reversal_buffer #(
  parameter int DATA_W = 8,
  parameter int LOG_N  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reverse_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
`ifdef BITREV_FRAME_FLAGS_EN
  output logic              out_first,
  output logic              out_last,
`endif
  input  logic              out_ready
);

  localparam int N = 2 ** LOG_N;
  localparam logic [LOG_N-1:0] IDX_LAST = '1;

  logic [DATA_W-1:0] mem [2][N];

  logic             wr_bank;
  logic [LOG_N-1:0] wr_idx;
  logic             rd_bank;
  logic [LOG_N-1:0] rd_idx;
  logic [1:0]       full;
  logic [1:0]       mode;

  logic             wr_fire;
  logic             rd_fire;
  logic [LOG_N-1:0] rd_addr;

  function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] v);
    logic [LOG_N-1:0] r;
    for (int i = 0; i < LOG_N; i++) begin
      r[i] = v[LOG_N-1-i];
    end
    return r;
  endfunction

  // Full flags guarantee the writer and reader never share a bank.
  assign in_ready  = ~full[wr_bank];
  assign out_valid = full[rd_bank];
  assign wr_fire   = in_valid & in_ready;
  assign rd_fire   = out_valid & out_ready;
  assign rd_addr   = mode[rd_bank] ? bitrev(rd_idx) : rd_idx;
  assign out_data  = out_valid ? mem[rd_bank][rd_addr] : '0;

`ifdef BITREV_FRAME_FLAGS_EN
  assign out_first = out_valid & (rd_idx == '0);
  assign out_last  = out_valid & (rd_idx == IDX_LAST);
`endif

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_bank][wr_idx] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank <= 1'b0;
      wr_idx  <= '0;
      rd_bank <= 1'b0;
      rd_idx  <= '0;
      full    <= '0;
      mode    <= '0;
    end else begin
      if (wr_fire) begin
        if (wr_idx == '0) begin
          mode[wr_bank] <= reverse_en;
        end
        if (wr_idx == IDX_LAST) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
          wr_idx        <= '0;
        end else begin
          wr_idx <= wr_idx + LOG_N'(1);
        end
      end
      if (rd_fire) begin
        if (rd_idx == IDX_LAST) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
          rd_idx        <= '0;
        end else begin
          rd_idx <= rd_idx + LOG_N'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bit_reversal_buffer.sv
// tb/tb_bit_reversal_buffer.sv - directed self-checking bench for bit_reversal_buffer
// Exercises an 8-word instance and a 16-word instance; checks flags when BITREV_FRAME_FLAGS_EN is set.
module tb_bit_reversal_buffer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] a_in_data, a_out_data;
  logic       a_in_valid, a_in_ready, a_reverse_en, a_out_valid, a_out_ready;
  logic [7:0] b_in_data, b_out_data;
  logic       b_in_valid, b_in_ready, b_reverse_en, b_out_valid, b_out_ready;
`ifdef BITREV_FRAME_FLAGS_EN
  logic       a_out_first, a_out_last, b_out_first, b_out_last;
`endif

  int total = 0;
  int bad   = 0;

  int tbl8[8]   = '{0, 4, 2, 6, 1, 5, 3, 7};
  int tbl16[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  bit_reversal_buffer #(.DATA_W(8), .LOG_N(3)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .reverse_en(a_reverse_en),
    .out_data(a_out_data), .out_valid(a_out_valid),
`ifdef BITREV_FRAME_FLAGS_EN
    .out_first(a_out_first), .out_last(a_out_last),
`endif
    .out_ready(a_out_ready)
  );

  bit_reversal_buffer #(.DATA_W(8), .LOG_N(4)) u_dut16 (
    .clk(clk), .rst(rst),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .reverse_en(b_reverse_en),
    .out_data(b_out_data), .out_valid(b_out_valid),
`ifdef BITREV_FRAME_FLAGS_EN
    .out_first(b_out_first), .out_last(b_out_last),
`endif
    .out_ready(b_out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Writes nframes consecutive frames while reading continuously; reverse_en flips mid-frame.
  task automatic run_stream(input int nframes, input int base, input logic rev);
    for (int c = 0; c < 8 * (nframes + 1); c++) begin
      int j;
      int exp_val;
      j = c % 8;
      a_in_valid   = (c < 8 * nframes);
      a_in_data    = 8'(base + c);
      a_reverse_en = (j == 0) ? rev : ~rev;
      a_out_ready  = 1'b1;
      if (c < 8 * nframes) chk("stream_in_ready", 32'(a_in_ready), 1);
      if (c < 8) begin
        chk("stream_latency_valid", 32'(a_out_valid), 0);
        chk("stream_latency_data", 32'(a_out_data), 0);
      end else begin
        exp_val = base + (c - 8) - j + (rev ? tbl8[j] : j);
        chk("stream_valid", 32'(a_out_valid), 1);
        chk("stream_data", 32'(a_out_data), 32'(exp_val));
`ifdef BITREV_FRAME_FLAGS_EN
        chk("stream_first", 32'(a_out_first), 32'(j == 0));
        chk("stream_last", 32'(a_out_last), 32'(j == 7));
`endif
      end
      tick();
    end
    a_in_valid = 1'b0;
    chk("stream_idle_valid", 32'(a_out_valid), 0);
  endtask

  initial begin
    rst = 1'b1;
    a_in_data = '0; a_in_valid = 1'b0; a_reverse_en = 1'b0; a_out_ready = 1'b0;
    b_in_data = '0; b_in_valid = 1'b0; b_reverse_en = 1'b0; b_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("reset_a_out_valid", 32'(a_out_valid), 0);
    chk("reset_a_out_data", 32'(a_out_data), 0);
    chk("reset_a_in_ready", 32'(a_in_ready), 1);
    chk("reset_b_out_valid", 32'(b_out_valid), 0);
    chk("reset_b_in_ready", 32'(b_in_ready), 1);
`ifdef BITREV_FRAME_FLAGS_EN
    chk("reset_a_first", 32'(a_out_first), 0);
    chk("reset_a_last", 32'(a_out_last), 0);
`endif

    // bit-reversed single frame, natural single frame, three back-to-back frames
    run_stream(1, 1, 1'b1);
    run_stream(1, 1, 1'b0);
    run_stream(3, 1, 1'b1);

    // backpressure: fill both banks with 1..16
    a_out_ready  = 1'b0;
    a_reverse_en = 1'b1;
    for (int c = 0; c < 16; c++) begin
      a_in_valid = 1'b1;
      a_in_data  = 8'(c + 1);
      chk("bp_fill_in_ready", 32'(a_in_ready), 1);
      tick();
    end
    a_in_data = 8'd99;
    for (int k = 0; k < 2; k++) begin
      chk("bp_full_in_ready", 32'(a_in_ready), 0);
      chk("bp_hold_valid", 32'(a_out_valid), 1);
      chk("bp_hold_data", 32'(a_out_data), 1);
      tick();
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      chk("bp_drain_in_ready", 32'(a_in_ready), 0);
      chk("bp_drain1_data", 32'(a_out_data), 32'(1 + tbl8[j]));
      tick();
    end
    chk("bp_ready_back", 32'(a_in_ready), 1);
    for (int j = 0; j < 8; j++) begin
      chk("bp_drain2_valid", 32'(a_out_valid), 1);
      chk("bp_drain2_data", 32'(a_out_data), 32'(9 + tbl8[j]));
      tick();
    end
    chk("bp_empty_valid", 32'(a_out_valid), 0);

    // reset with one complete frame pending and a partial frame of 5 words
    a_out_ready = 1'b0;
    for (int c = 0; c < 13; c++) begin
      a_in_valid = 1'b1;
      a_in_data  = 8'(100 + c);
      tick();
    end
    a_in_valid = 1'b0;
    chk("rst_pre_valid", 32'(a_out_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_valid", 32'(a_out_valid), 0);
    chk("rst_async_data", 32'(a_out_data), 0);
    chk("rst_async_in_ready", 32'(a_in_ready), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_stream(1, 11, 1'b1);

    // 16-word instance: input 0..15 bit-reversed
    for (int c = 0; c < 32; c++) begin
      b_in_valid   = (c < 16);
      b_in_data    = 8'(c);
      b_reverse_en = 1'b1;
      b_out_ready  = 1'b1;
      if (c < 16) begin
        chk("n16_in_ready", 32'(b_in_ready), 1);
        chk("n16_latency_valid", 32'(b_out_valid), 0);
      end else begin
        chk("n16_valid", 32'(b_out_valid), 1);
        chk("n16_data", 32'(b_out_data), 32'(tbl16[c - 16]));
`ifdef BITREV_FRAME_FLAGS_EN
        chk("n16_first", 32'(b_out_first), 32'(c == 16));
        chk("n16_last", 32'(b_out_last), 32'(c == 31));
`endif
      end
      tick();
    end
    b_in_valid = 1'b0;
    chk("n16_idle_valid", 32'(b_out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
